// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported word memory between instruction fetch (IF) and load/store (LS),
// with registered read return and a two-cycle read-modify-write for partial-word stores.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,

    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [AWIDTH-1:0] ls_addr_i,
    input  logic [DWIDTH-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DWIDTH-1:0] ls_rdata_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,

    output logic              busy_o
);

    localparam int             CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     starve_q;
    logic [AWIDTH-1:0] rmw_addr_q;
    logic [DWIDTH-1:0] rmw_data_q;

    logic              ls_wins, if_wins;
    logic [AWIDTH-1:0] if_word_addr, ls_word_addr;
    logic [DWIDTH-1:0] merged_word;
    logic              rmw_capture;
    logic              ls_done;
    logic              ls_load;

    assign if_word_addr = {if_addr_i[AWIDTH-1:2], 2'b00};
    assign ls_word_addr = {ls_addr_i[AWIDTH-1:2], 2'b00};

    // LS has priority until IF has lost STARVE_LIMIT cycles in a row.
    assign ls_wins = ls_req_i && (!if_req_i || (starve_q < STARVE_MAX));
    assign if_wins = if_req_i && !ls_wins;

    always_comb begin
        merged_word = mem_data_i;
        for (int i = 0; i < 4; i++) begin
            if (ls_be_i[i]) merged_word[8*i +: 8] = ls_wdata_i[8*i +: 8];
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d        = state_q;
        if_gnt_o       = 1'b0;
        ls_gnt_o       = 1'b0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        busy_o         = 1'b0;
        rmw_capture    = 1'b0;
        ls_done        = 1'b0;
        ls_load        = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (if_wins) begin
                        if_gnt_o      = 1'b1;
                        mem_addr_o    = if_word_addr;
                        mem_read_en_o = 1'b1;
                    end else if (ls_wins) begin
                        ls_gnt_o   = 1'b1;
                        mem_addr_o = ls_word_addr;
                        if (!ls_we_i) begin
                            mem_read_en_o = 1'b1;
                            ls_done       = 1'b1;
                            ls_load       = 1'b1;
                        end else if (ls_be_i == 4'hF) begin
                            mem_write_en_o = 1'b1;
                            mem_data_o     = ls_wdata_i;
                            ls_done        = 1'b1;
                        end else if (ls_be_i == 4'h0) begin
                            ls_done = 1'b1;
                        end else begin
                            // Partial store: read the old word now, write the merge next cycle.
                            mem_read_en_o = 1'b1;
                            rmw_capture   = 1'b1;
                            state_d       = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    mem_addr_o     = rmw_addr_q;
                    mem_data_o     = rmw_data_q;
                    mem_write_en_o = 1'b1;
                    busy_o         = 1'b1;
                    ls_done        = 1'b1;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
        end else begin
            state_q <= state_d;

            if (if_gnt_o) begin
                starve_q <= '0;
            end else if (if_req_i && (starve_q != STARVE_MAX)) begin
                starve_q <= starve_q + CW'(1);
            end

            if_rvalid_o <= if_gnt_o;
            if (if_gnt_o) if_rdata_o <= mem_data_i;

            ls_rvalid_o <= ls_done;
            if (ls_done) ls_rdata_o <= ls_load ? mem_data_i : '0;
        end
    end

    // NOTE: pure datapath holding registers need no reset; they are only read in RMW_WR, which always follows a capture.
    always_ff @(posedge clk) begin
        if (rmw_capture) begin
            rmw_addr_q <= ls_word_addr;
            rmw_data_q <= merged_word;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// compared cycle by cycle against a word-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i, ls_we_i;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_addr_i, ls_wdata_i;
    logic        ls_gnt_o, ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_read_en_o, mem_write_en_o, busy_o;

    mem_port_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, synchronous word write, 256 words.
    logic [31:0] mem [0:255];
    assign mem_data_i = mem[mem_addr_o[9:2]];
    always @(posedge clk) if (mem_write_en_o) mem[mem_addr_o[9:2]] <= mem_data_o;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          m_starve;
    bit          m_rmw_pending;
    logic [31:0] m_rmw_addr, m_rmw_data;
    bit          reg_known, e_if_rv, e_ls_rv, e_rdata_zero;
    logic [31:0] e_if_rd, e_ls_rd;
    bit          last_if_gnt, last_ls_gnt;

    int checks = 0;
    int passed = 0;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive at negedge, check registered outputs from the previous
    // edge and combinational outputs for this cycle, then advance the model.
    task automatic cycle(input logic r, input logic ir, input logic [31:0] ia,
                         input logic lr, input logic lwe, input logic [3:0] lbe,
                         input logic [31:0] la, input logic [31:0] lwd);
        bit          x_ifg, x_lsg, x_rd, x_wr, x_busy, ls_win;
        logic [31:0] x_addr, x_data;
        bit          n_if_rv, n_ls_rv;
        logic [31:0] n_if_rd, n_ls_rd;
        int          idx;

        @(negedge clk);
        rst = r; if_req_i = ir; if_addr_i = ia;
        ls_req_i = lr; ls_we_i = lwe; ls_be_i = lbe; ls_addr_i = la; ls_wdata_i = lwd;
        #1;

        if (reg_known) begin
            check("if_rvalid", if_rvalid_o, e_if_rv);
            check("ls_rvalid", ls_rvalid_o, e_ls_rv);
            if (e_if_rv || e_rdata_zero) check("if_rdata", if_rdata_o, e_if_rd);
            if (e_ls_rv || e_rdata_zero) check("ls_rdata", ls_rdata_o, e_ls_rd);
        end

        x_ifg = 0; x_lsg = 0; x_rd = 0; x_wr = 0; x_busy = 0;
        x_addr = '0; x_data = '0;
        n_if_rv = 0; n_ls_rv = 0; n_if_rd = '0; n_ls_rd = '0;

        if (r) begin
            m_starve      = 0;
            m_rmw_pending = 0;
        end else if (m_rmw_pending) begin
            x_wr = 1; x_busy = 1;
            x_addr = m_rmw_addr; x_data = m_rmw_data;
            ref_mem[m_rmw_addr[9:2]] = m_rmw_data;
            n_ls_rv = 1;
            m_rmw_pending = 0;
        end else begin
            ls_win = lr && (!ir || m_starve < LIMIT);
            x_lsg  = ls_win;
            x_ifg  = ir && !ls_win;
            if (x_ifg) begin
                x_rd = 1; x_addr = {ia[31:2], 2'b00};
                n_if_rv = 1; n_if_rd = ref_mem[ia[9:2]];
            end else if (x_lsg) begin
                x_addr = {la[31:2], 2'b00};
                idx = int'(la[9:2]);
                if (!lwe) begin
                    x_rd = 1; n_ls_rv = 1; n_ls_rd = ref_mem[idx];
                end else if (lbe == 4'hF) begin
                    x_wr = 1; x_data = lwd; n_ls_rv = 1;
                    ref_mem[idx] = lwd;
                end else if (lbe == 4'h0) begin
                    n_ls_rv = 1;
                end else begin
                    x_rd = 1;
                    m_rmw_pending = 1;
                    m_rmw_addr = x_addr;
                    m_rmw_data = (ref_mem[idx] & ~be_mask(lbe)) | (lwd & be_mask(lbe));
                end
            end
        end
        if (!r) begin
            if (x_ifg) m_starve = 0;
            else if (ir && m_starve < LIMIT) m_starve++;
        end

        check("if_gnt", if_gnt_o, x_ifg);
        check("ls_gnt", ls_gnt_o, x_lsg);
        check("mem_read_en", mem_read_en_o, x_rd);
        check("mem_write_en", mem_write_en_o, x_wr);
        check("busy", busy_o, x_busy);
        if (x_rd || x_wr || r) check("mem_addr", mem_addr_o, x_addr);
        if (x_wr || r) check("mem_data", mem_data_o, x_data);

        e_if_rv = n_if_rv; e_ls_rv = n_ls_rv;
        e_if_rd = n_if_rd; e_ls_rd = n_ls_rd;
        e_rdata_zero = r;
        if (r) reg_known = 1;
        last_if_gnt = x_ifg;
        last_ls_gnt = x_lsg;
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, 4'h0, '0, '0);
    endtask

    initial begin
        logic [7:0]  pat;
        bit          ip, lp, lwe, r;
        logic [31:0] ia, la, lwd;
        logic [3:0]  lbe;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        m_starve = 0; m_rmw_pending = 0; reg_known = 0;
        e_if_rv = 0; e_ls_rv = 0; e_rdata_zero = 0;
        rst = 1; if_req_i = 0; if_addr_i = '0;
        ls_req_i = 0; ls_we_i = 0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;

        // Reset held two cycles with both requests active
        cycle(1, 1, 32'h0100_0004, 1, 0, 4'hF, 32'h0100_0010, 32'h0);
        cycle(1, 1, 32'h0100_0004, 1, 0, 4'hF, 32'h0100_0010, 32'h0);

        // IF alone
        cycle(0, 1, 32'h0100_0004, 0, 0, 4'h0, '0, '0);
        idle();
        check("if_fetch_valid", if_rvalid_o, 1'b1);

        // Full store then load back
        cycle(0, 0, '0, 1, 1, 4'hF, 32'h0100_0010, 32'hDEAD_BEEF);
        cycle(0, 0, '0, 1, 0, 4'hF, 32'h0100_0010, 32'h0);
        idle();
        check("load_after_store", ls_rdata_o, 32'hDEAD_BEEF);

        // Partial store with IF requesting during the RMW
        cycle(0, 0, '0, 1, 1, 4'hF, 32'h0100_0020, 32'h1122_3344);
        cycle(0, 1, 32'h0100_0008, 1, 1, 4'b0010, 32'h0100_0020, 32'h0000_AA00);
        cycle(0, 1, 32'h0100_0008, 0, 0, 4'h0, '0, '0);
        check("rmw_busy", busy_o, 1'b1);
        check("rmw_if_blocked", if_gnt_o, 1'b0);
        cycle(0, 1, 32'h0100_0008, 0, 0, 4'h0, '0, '0);
        cycle(0, 0, '0, 1, 0, 4'h0, 32'h0100_0020, 32'h0);
        idle();
        check("rmw_readback", ls_rdata_o, 32'h1122_AA44);

        // Continuous contention from a cleared starvation count
        cycle(0, 1, 32'h0100_000C, 0, 0, 4'h0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 32'h0100_0030, 1, 0, 4'h0, 32'h0100_0034 + 32'(i * 4), 32'h0);
            pat[i] = ls_gnt_o;
        end
        check("starve_pattern", {24'h0, pat}, 32'h0000_0077);
        idle();

        // Reset during RMW_WR aborts the write
        cycle(0, 0, '0, 1, 1, 4'hF, 32'h0100_0040, 32'hCAFE_F00D);
        cycle(0, 0, '0, 1, 1, 4'b0001, 32'h0100_0040, 32'h0000_00FF);
        cycle(1, 0, '0, 0, 0, 4'h0, '0, '0);
        check("rmw_abort_mem", mem[16], 32'hCAFE_F00D);
        cycle(0, 0, '0, 1, 0, 4'h0, 32'h0100_0040, 32'h0);
        idle();
        check("rmw_abort_load", ls_rdata_o, 32'hCAFE_F00D);

        // Randomized traffic honouring hold-until-grant
        ip = 0; lp = 0; ia = '0; la = '0; lwd = '0; lwe = 0; lbe = '0;
        for (int n = 0; n < 400; n++) begin
            if (!ip) begin
                ip = 1'($urandom_range(0, 1));
                ia = $urandom;
            end
            if (!lp) begin
                lp  = 1'($urandom_range(0, 1));
                lwe = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       lbe = 4'hF;
                    1:       lbe = 4'h0;
                    default: lbe = 4'($urandom);
                endcase
                la  = $urandom;
                lwd = $urandom;
            end
            r = ($urandom_range(0, 99) == 0);
            cycle(r, ip, ia, lp, lwe, lbe, la, lwd);
            if (last_if_gnt) ip = 0;
            if (last_ls_gnt) lp = 0;
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
